// File: rtl/serial_mult_seq.sv
// Multi-cycle shift-and-add unsigned multiplier tile with a start/busy/done handshake.
// Adds one partial product per clock, so a product takes WIDTH cycles in RUN.
module serial_mult_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mult_q, mult_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [CW-1:0]    count_q, count_d;
  logic             done_q, done_d;
  logic             start_q;

  logic             start_edge;
  logic             busy;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_sum;
  logic [7:0]       prod_ext;

  assign start_edge = uio_in[0] & ~start_q;

  // Partial product for this step; 2*WIDTH bits so the running sum cannot overflow.
  assign addend  = mult_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << count_q) : '0;
  assign acc_sum = acc_q + addend;

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mult_d  = mult_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    count_d = count_q;
    done_d  = done_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_edge) begin
          mcand_d = ui_in[WIDTH-1:0];
          mult_d  = ui_in[WIDTH+3:4];
          acc_d   = '0;
          count_d = '0;
          done_d  = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d   = acc_sum;
        mult_d  = mult_q >> 1;
        count_d = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) begin
          prod_d  = acc_sum;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mcand_q <= '0;
      mult_q  <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mult_q  <= mult_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      count_q <= count_d;
      done_q  <= done_d;
      start_q <= uio_in[0];
    end
  end

  // Decoded from the state register only, so no input can glitch it.
  assign busy = (state_q == StRun);

  always_comb begin
    prod_ext           = '0;
    prod_ext[PW-1:0]   = prod_q;
  end

  assign uo_out  = prod_ext;
  assign uio_out = {5'b0, done_q, busy, 1'b0};
  assign uio_oe  = 8'b0000_0110;

  logic unused_inputs;
  assign unused_inputs = ^{ena, uio_in[7:1], ui_in};

endmodule

// File: tb/tb_serial_mult_seq.sv
// Directed bench for serial_mult_seq: handshake, latency, products and reset behaviour.
module tb_serial_mult_seq;

  logic       clk;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;

  int vectors;
  int miscompares;

  serial_mult_seq #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One start pulse; counts busy cycles, then checks product, done and hold.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp,
                        input string tag);
    logic [7:0] prev;
    int         busy_n;
    prev = uo_out;
    @(negedge clk);
    ui_in  = {b, a};
    uio_in = 8'h01;
    @(negedge clk);
    uio_in = 8'h00;
    busy_n = 0;
    chk({tag, " busy_start"}, {31'b0, uio_out[1]}, 32'd1);
    chk({tag, " prev_held"}, {24'b0, uo_out}, {24'b0, prev});
    while (uio_out[1] && busy_n < 20) begin
      busy_n++;
      @(negedge clk);
    end
    chk({tag, " busy_cycles"}, busy_n, 32'd4);
    chk({tag, " done"}, {31'b0, uio_out[2]}, 32'd1);
    chk({tag, " product"}, {24'b0, uo_out}, {24'b0, exp});
    repeat (2) @(negedge clk);
    chk({tag, " product_hold"}, {24'b0, uo_out}, {24'b0, exp});
    chk({tag, " done_hold"}, {29'b0, uio_out[2:0]}, 32'd4);
  endtask

  logic [7:0] b2b_ops [4];
  logic [7:0] b2b_exp [4];

  initial begin
    int  busy_n;
    int  t;
    int  last;
    int  k;
    int  guard;
    logic prev_done;
    logic cur_done;

    vectors     = 0;
    miscompares = 0;
    rst_n  = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    ena    = 1'b1;

    // Reset then idle
    repeat (2) @(negedge clk);
    chk("reset uo_out", {24'b0, uo_out}, 32'h00);
    chk("reset uio_out", {24'b0, uio_out}, 32'h00);
    chk("reset uio_oe", {24'b0, uio_oe}, 32'h06);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle uo_out", {24'b0, uo_out}, 32'h00);
      chk("idle uio_out", {24'b0, uio_out}, 32'h00);
      chk("idle uio_oe", {24'b0, uio_oe}, 32'h06);
    end

    // Basic, max and zero operands
    run_op(4'd3, 4'd5, 8'h0F, "3x5");
    run_op(4'd15, 4'd15, 8'hE1, "15x15");
    run_op(4'd0, 4'd9, 8'h00, "0x9");

    // Start held high for 6 cycles with operand change during RUN
    @(negedge clk);
    ui_in  = {4'd6, 4'd7};
    uio_in = 8'h01;
    busy_n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 1) ui_in = 8'h11;
      if (i == 5) uio_in = 8'h00;
      busy_n += int'(uio_out[1]);
    end
    chk("held busy_cycles", busy_n, 32'd4);
    chk("held product", {24'b0, uo_out}, 32'h2A);
    chk("held done", {31'b0, uio_out[2]}, 32'd1);

    // Reset mid-operation
    run_op(4'd3, 4'd5, 8'h0F, "pre_reset 3x5");
    @(negedge clk);
    ui_in  = {4'd9, 4'd9};
    uio_in = 8'h01;
    @(negedge clk);
    uio_in = 8'h00;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset uo_out", {24'b0, uo_out}, 32'h00);
    chk("midreset uio_out", {24'b0, uio_out}, 32'h00);
    @(negedge clk);
    chk("midreset held uo_out", {24'b0, uo_out}, 32'h00);
    rst_n = 1'b1;
    run_op(4'd2, 4'd3, 8'h06, "post_reset 2x3");

    // Back-to-back: restart on the cycle after each done rise
    b2b_ops[0] = {4'd13, 4'd11}; b2b_exp[0] = 8'h8F;
    b2b_ops[1] = {4'd9,  4'd6};  b2b_exp[1] = 8'h36;
    b2b_ops[2] = {4'd1,  4'd15}; b2b_exp[2] = 8'h0F;
    b2b_ops[3] = {4'd12, 4'd4};  b2b_exp[3] = 8'h30;
    @(negedge clk);
    t     = 0;
    last  = 0;
    k     = 0;
    guard = 0;
    prev_done = uio_out[2];
    ui_in  = b2b_ops[0];
    uio_in = 8'h01;
    while (k < 4 && guard < 100) begin
      @(negedge clk);
      t++;
      guard++;
      uio_in   = 8'h00;
      cur_done = uio_out[2];
      if (cur_done && !prev_done) begin
        chk($sformatf("b2b%0d product", k), {24'b0, uo_out}, {24'b0, b2b_exp[k]});
        if (k > 0) chk($sformatf("b2b%0d spacing", k), t - last, 32'd5);
        last = t;
        k++;
        if (k < 4) begin
          ui_in  = b2b_ops[k];
          uio_in = 8'h01;
        end
      end
      prev_done = cur_done;
    end
    chk("b2b completed", k, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_mult_seq.md
Name: serial_mult_seq

Overview:
- Sequencing controller that runs the team's adder datapath as a multi-cycle shift-and-add unsigned multiplier.
- Sits as a pin-level top-level tile: operands on the dedicated inputs, start on a bidirectional input, product on the dedicated outputs, busy/done status on bidirectional outputs.
- Replaces the purely combinational bit-level experiment with a start/busy/done handshake and one partial-product add per clock.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..4; product width is 2*WIDTH (at most 8, the width of uo_out).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronous to clk externally.
- ui_in  input  8  [WIDTH-1:0] = operand A (multiplicand); [WIDTH+3:4] = operand B (multiplier); other bits unused.
- uo_out  output  8  registered product, zero-extended to 8 bits.
- uio_in  input  8  bit 0 = start; other bits unused.
- uio_out  output  8  bit 1 = busy, bit 2 = done; all other bits constant 0.
- uio_oe  output  8  constant 8'b0000_0110.
- ena  input  1  ignored; block is always active.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; uo_out=0; busy=0; done=0; count=0; accumulator, operand registers and start_q=0.
- Start detection: start_q <= uio_in[0] every cycle; start_edge = uio_in[0] & ~start_q.
  - start held high through reset release gives one start_edge on the first clock after release.
- States: IDLE, RUN, DONE.
- IDLE or DONE, start_edge=1:
  - capture A and B from ui_in; acc=0; count=0; done=0.
  - go to RUN.
- RUN, one step per clock:
  - if mult[0]=1, acc <= acc + (mcand << count), computed in 2*WIDTH bits; cannot overflow.
  - mult <= mult >> 1; count <= count+1.
  - on the step where count==WIDTH-1: load uo_out with the final accumulator value (including that step's add); done=1; go to DONE.
- DONE: uo_out and done hold until the next start_edge.
- Outputs:
  - busy = 1 exactly while in RUN, combinationally decoded from the state register (no glitch path from inputs).
  - uo_out changes only on completion; during RUN it holds the previous product.
- Latency:
  - capture edge = E0; done and new uo_out are visible after edge E0+WIDTH.
  - busy is high for exactly WIDTH cycles.
  - earliest restart: start_edge in the cycle after done rises; back-to-back throughput is WIDTH+1 cycles per product.
- start_edge while in RUN: ignored; operands and the sequence are unaffected. Holding start high does not retrigger.
- ui_in changes during RUN: no effect, because operands are registered at capture.
- Reset mid-RUN: immediate return to reset values; no partial product reaches uo_out.
- Operand zero: the full WIDTH steps still execute; latency is constant and does not depend on data.
- Unused input bits are ignored; unused output bits are constant 0.

Test Plan:
- Reset then idle: rst_n=0 then 1, start=0 for 10 cycles -> uo_out=0x00, busy=0, done=0, uio_oe=0x06 throughout.
- Basic product: A=3, B=5, pulse start for 1 cycle -> busy=1 for exactly 4 cycles; then done=1 and uo_out=0x0F, both held until the next start.
- Max and zero operands:
  - A=15, B=15 -> uo_out=0xE1 (225).
  - then A=0, B=9 -> uo_out=0x00.
  - both complete in 4 busy cycles.
- Start during busy, start held high, operand change:
  - A=7, B=6; keep start high 6 cycles and change ui_in to A=1, B=1 during RUN -> one operation only, uo_out=0x2A (42).
  - no second busy period until start falls and rises again.
- Reset mid-operation: A=9, B=9 after a previous result 0x0F; assert rst_n=0 two cycles after start -> uo_out=0, busy=0, done=0 immediately. After release, A=2, B=3 start -> uo_out=0x06.
- Back-to-back: issue start on the cycle after done rises, for 4 random pairs -> each product correct; successive done rises spaced exactly 5 cycles apart.
